// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package nibble_serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Digit-index width; at least one bit even for a single-digit configuration.
   function automatic int k_width(input int steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

   localparam int DEFAULT_STEPS = 2;
   localparam int K_W           = k_width(DEFAULT_STEPS);

endpackage

// File: rtl/nibble_serial_subtractor_nbit_adder.sv
// Plain ripple adder reused one digit at a time by the serial subtractor.
module nbitAdder #(
   parameter int bits = 4
) (
   input  logic [bits-1:0] a,
   input  logic [bits-1:0] b,
   input  logic            cin,
   output logic [bits-1:0] y,
   output logic            cOut
);

   assign {cOut, y} = {1'b0, a} + {1'b0, b} + {{bits{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Digit-serial a - b - bin behind a valid/ready handshake; one DIGIT-bit digit per clock.
module nibble_serial_subtractor
   import nibble_serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int KW    = k_width(STEPS);
   localparam int MSB   = WIDTH - 1;
   localparam logic [KW-1:0] K_LAST = KW'(STEPS - 1);

   state_t           state_reg, state_next;
   logic [KW-1:0]    k_reg, k_next;
   logic             carry_reg, carry_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH-1:0] b_reg, b_next;
   logic [WIDTH-1:0] diff_reg, diff_next;
   logic             bout_reg, bout_next;
   logic             zero_reg, zero_next;
   logic             ovf_reg, ovf_next;

   logic [31:0]      sel;
   logic [DIGIT-1:0] a_dig, b_dig, sum_dig;
   logic             c_out;

   assign sel   = 32'(k_reg) * DIGIT;
   assign a_dig = a_reg[sel +: DIGIT];
   assign b_dig = b_reg[sel +: DIGIT];

   // Subtraction as a + ~b + 1; the carry register holds the inverted borrow.
   nbitAdder #(.bits(DIGIT)) u_adder (
      .a    (a_dig),
      .b    (~b_dig),
      .cin  (carry_reg),
      .y    (sum_dig),
      .cOut (c_out)
   );

   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      carry_next = carry_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      diff_next  = diff_reg;
      bout_next  = bout_reg;
      zero_next  = zero_reg;
      ovf_next   = ovf_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               state_next = RUN;
               a_next     = a;
               b_next     = b;
               carry_next = ~bin;
               k_next     = '0;
               diff_next  = '0;
            end
         end
         RUN: begin
            diff_next[sel +: DIGIT] = sum_dig;
            carry_next              = c_out;
            k_next                  = k_reg + KW'(1);
            if (k_reg == K_LAST) begin
               // Flags are taken from the fully assembled result, including the last digit.
               state_next = DONE;
               k_next     = '0;
               bout_next  = ~c_out;
               zero_next  = (diff_next == '0);
               ovf_next   = (a_reg[MSB] != b_reg[MSB]) && (diff_next[MSB] != a_reg[MSB]);
            end
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         k_reg     <= '0;
         carry_reg <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         diff_reg  <= '0;
         bout_reg  <= 1'b0;
         zero_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         k_reg     <= k_next;
         carry_reg <= carry_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         diff_reg  <= diff_next;
         bout_reg  <= bout_next;
         zero_reg  <= zero_next;
         ovf_reg   <= ovf_next;
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign diff      = diff_reg;
   assign bout      = bout_reg;
   assign zero      = zero_reg;
   assign ovf       = ovf_reg;

endmodule
